imem_fetch_ctrl: RTL and testbench



---
 rtl/imem_fetch_ctrl_if.sv | 32 +++
 rtl/imem_fetch_ctrl.sv | 107 ++++++++++
 tb/tb_imem_fetch_ctrl.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/imem_fetch_ctrl_if.sv
// Bundle of fetch, loader and instruction-memory signals around imem_fetch_ctrl.
// The slave modport is the controller; master is the requester/memory side.
interface imem_fetch_ctrl_if #(
    parameter int ADDR_W = 8
);
    logic              fetch_req;
    logic [ADDR_W-1:0] fetch_addr;
    logic              fetch_valid;
    logic [31:0]       fetch_instr;

    logic              load_req;
    logic [ADDR_W-1:0] load_addr;
    logic [7:0]        load_data;
    logic              load_ack;

    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [7:0]        mem_wdata;
    logic [7:0]        mem_rdata;

    logic              busy;

    modport master (
        output fetch_req, fetch_addr, load_req, load_addr, load_data, mem_rdata,
        input  fetch_valid, fetch_instr, load_ack, mem_addr, mem_we, mem_wdata, busy
    );

    modport slave (
        input  fetch_req, fetch_addr, load_req, load_addr, load_data, mem_rdata,
        output fetch_valid, fetch_instr, load_ack, mem_addr, mem_we, mem_wdata, busy
    );
endinterface

// File: rtl/imem_fetch_ctrl.sv
// Byte-wide instruction-memory sequencer: four byte reads -> one 32-bit LE word.
// Define IMEM_LOADER_EN to add the byte loader port with round-robin arbitration.
module imem_fetch_ctrl #(
    parameter int ADDR_W = 8
) (
    input logic               clk,
    input logic               rst,
    imem_fetch_ctrl_if.slave  bus
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_RESP  = 2'd2;
`ifdef IMEM_LOADER_EN
    localparam logic [1:0] S_WRITE = 2'd3;
`endif

    logic [1:0]        state;
    logic [1:0]        cnt;
    logic [ADDR_W-1:0] base;
    logic [23:0]       byte_buf;
    logic [31:0]       instr_q;
    logic              grant_fetch;

`ifdef IMEM_LOADER_EN
    logic              last_grant;  // 1 = load was granted last
    logic              grant_load;
    logic              tie;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;

    always_comb begin
        tie         = bus.fetch_req & bus.load_req;
        grant_fetch = bus.fetch_req & (~bus.load_req | last_grant);
        grant_load  = bus.load_req & (~bus.fetch_req | ~last_grant);
    end
`else
    logic unused_inputs;
    assign unused_inputs = ^{bus.load_req, bus.load_addr, bus.load_data, bus.fetch_addr[1:0]};
    assign grant_fetch   = bus.fetch_req;
`endif

    // NOTE: state is updated with non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            cnt      <= '0;
            base     <= '0;
            byte_buf <= '0;
            instr_q  <= '0;
`ifdef IMEM_LOADER_EN
            last_grant <= 1'b1;
            wr_addr    <= '0;
            wr_data    <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (grant_fetch) begin
                        state <= S_FETCH;
                        base  <= {bus.fetch_addr[ADDR_W-1:2], 2'b00};
                        cnt   <= '0;
`ifdef IMEM_LOADER_EN
                        if (tie) last_grant <= 1'b0;
                    end else if (grant_load) begin
                        state   <= S_WRITE;
                        wr_addr <= bus.load_addr;
                        wr_data <= bus.load_data;
                        if (tie) last_grant <= 1'b1;
`endif
                    end
                end
                S_FETCH: begin
                    cnt <= cnt + 2'd1;
                    // Byte 3 goes straight into the result so it is visible during RESP.
                    if (cnt == 2'd3) begin
                        instr_q <= {bus.mem_rdata, byte_buf};
                        state   <= S_RESP;
                    end else begin
                        byte_buf <= {bus.mem_rdata, byte_buf[23:8]};
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // NOTE: every output gets a default before the state decode so no latch is inferred.
    always_comb begin
        bus.fetch_valid = (state == S_RESP);
        bus.busy        = (state != S_IDLE);
        bus.fetch_instr = instr_q;
        bus.mem_addr    = '0;
        bus.mem_we      = 1'b0;
        bus.mem_wdata   = '0;
        bus.load_ack    = 1'b0;
        if (state == S_FETCH) bus.mem_addr = base | ADDR_W'(cnt);
`ifdef IMEM_LOADER_EN
        if (state == S_WRITE) begin
            bus.mem_addr  = wr_addr;
            bus.mem_wdata = wr_data;
            bus.mem_we    = 1'b1;
            bus.load_ack  = 1'b1;
        end
`endif
    end
endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Directed bench for imem_fetch_ctrl with a 256-byte behavioural memory.
// Loader scenarios run only when IMEM_LOADER_EN is defined.
module tb_imem_fetch_ctrl;
    logic clk = 1'b0;
    logic rst;
    logic [7:0] mem [256];
    int checks = 0;
    int errors = 0;

    imem_fetch_ctrl_if #(.ADDR_W(8)) bus ();

    imem_fetch_ctrl #(.ADDR_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    assign bus.mem_rdata = mem[bus.mem_addr];

    always @(posedge clk) begin
        if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Entered and left at a falling edge with the DUT in IDLE.
    task automatic do_fetch(input logic [7:0] addr, input logic [31:0] exp,
                            input string tag, input bit toggle_load);
        logic [7:0] b;
        b = addr & 8'hFC;
        bus.fetch_req  = 1'b1;
        bus.fetch_addr = addr;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (toggle_load) bus.load_req = 1'($urandom_range(0, 1));
            check({tag, "_addr"}, 32'(bus.mem_addr), 32'(b + 8'(i)));
            check({tag, "_busy"}, 32'(bus.busy), 32'd1);
            check({tag, "_early_valid"}, 32'(bus.fetch_valid), 32'd0);
            check({tag, "_we"}, 32'(bus.mem_we), 32'd0);
        end
        @(negedge clk);
        check({tag, "_valid"}, 32'(bus.fetch_valid), 32'd1);
        check({tag, "_instr"}, bus.fetch_instr, exp);
        check({tag, "_we_resp"}, 32'(bus.mem_we), 32'd0);
        bus.fetch_req = 1'b0;
        bus.load_req  = 1'b0;
        @(negedge clk);
        check({tag, "_valid_drop"}, 32'(bus.fetch_valid), 32'd0);
        check({tag, "_idle"}, 32'(bus.busy), 32'd0);
        check({tag, "_instr_hold"}, bus.fetch_instr, exp);
    endtask

`ifdef IMEM_LOADER_EN
    task automatic do_load(input logic [7:0] addr, input logic [7:0] data, input string tag);
        bus.load_req  = 1'b1;
        bus.load_addr = addr;
        bus.load_data = data;
        @(negedge clk);
        check({tag, "_we"}, 32'(bus.mem_we), 32'd1);
        check({tag, "_ack"}, 32'(bus.load_ack), 32'd1);
        check({tag, "_addr"}, 32'(bus.mem_addr), 32'(addr));
        check({tag, "_wdata"}, 32'(bus.mem_wdata), 32'(data));
        bus.load_req = 1'b0;
        @(negedge clk);
        check({tag, "_ack_drop"}, 32'(bus.load_ack), 32'd0);
        check({tag, "_we_drop"}, 32'(bus.mem_we), 32'd0);
        check({tag, "_busy"}, 32'(bus.busy), 32'd0);
        check({tag, "_written"}, 32'(mem[addr]), 32'(data));
    endtask
`endif

    initial begin
        foreach (mem[i]) mem[i] = 8'h00;
        {mem[0], mem[1], mem[2], mem[3]}         = {8'h03, 8'h00, 8'h08, 8'h21};
        {mem[8], mem[9], mem[10], mem[11]}       = {8'h01, 8'h02, 8'h03, 8'h04};
        {mem[64], mem[65], mem[66], mem[67]}     = {8'h11, 8'h22, 8'h33, 8'h44};
        {mem[252], mem[253], mem[254], mem[255]} = {8'hEF, 8'hBE, 8'hAD, 8'hDE};

        bus.fetch_req  = 1'b0;
        bus.fetch_addr = '0;
        bus.load_req   = 1'b0;
        bus.load_addr  = '0;
        bus.load_data  = '0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_valid", 32'(bus.fetch_valid), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_instr", bus.fetch_instr, 32'd0);
        check("rst_ack", 32'(bus.load_ack), 32'd0);
        check("rst_we", 32'(bus.mem_we), 32'd0);
        check("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
        check("rst_wdata", 32'(bus.mem_wdata), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        do_fetch(8'h02, 32'h2108_0003, "single", 1'b0);
        do_fetch(8'hFF, 32'hDEAD_BEEF, "top", 1'b0);

        // Reset lands with cnt = 2: partial fetch must vanish.
        bus.fetch_req  = 1'b1;
        bus.fetch_addr = 8'h40;
        repeat (3) @(negedge clk);
        check("mid_busy_pre", 32'(bus.busy), 32'd1);
        check("mid_addr_pre", 32'(bus.mem_addr), 32'h42);
        rst = 1'b1;
        bus.fetch_req = 1'b0;
        #1;
        check("mid_rst_valid", 32'(bus.fetch_valid), 32'd0);
        check("mid_rst_busy", 32'(bus.busy), 32'd0);
        check("mid_rst_we", 32'(bus.mem_we), 32'd0);
        check("mid_rst_addr", 32'(bus.mem_addr), 32'd0);
        check("mid_rst_instr", bus.fetch_instr, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("post_rst_valid", 32'(bus.fetch_valid), 32'd0);
            check("post_rst_busy", 32'(bus.busy), 32'd0);
        end

`ifdef IMEM_LOADER_EN
        do_load(8'h0B, 8'hAD, "load");
        do_fetch(8'h08, 32'hAD03_0201, "after_load", 1'b0);

        // Fresh reset so the first tie goes to fetch.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        bus.fetch_req  = 1'b1;
        bus.fetch_addr = 8'h40;
        bus.load_req   = 1'b1;
        bus.load_addr  = 8'h41;
        bus.load_data  = 8'h5A;
        for (int t = 0; t < 4; t++) begin
            if (t > 0) begin
                @(negedge clk);
                check("cont_idle", 32'(bus.busy), 32'd0);
            end
            @(negedge clk);
            if (t % 2 == 0) begin
                check("cont_fetch_we", 32'(bus.mem_we), 32'd0);
                check("cont_fetch_addr", 32'(bus.mem_addr), 32'h40);
                repeat (4) @(negedge clk);
                check("cont_fetch_valid", 32'(bus.fetch_valid), 32'd1);
                check("cont_fetch_instr", bus.fetch_instr, (t == 0) ? 32'h4433_2211 : 32'h4433_5A11);
            end else begin
                check("cont_load_we", 32'(bus.mem_we), 32'd1);
                check("cont_load_ack", 32'(bus.load_ack), 32'd1);
                check("cont_load_addr", 32'(bus.mem_addr), 32'h41);
            end
        end
        bus.fetch_req = 1'b0;
        bus.load_req  = 1'b0;
        @(negedge clk);
        check("cont_done_busy", 32'(bus.busy), 32'd0);
        check("cont_mem", 32'(mem[65]), 32'h5A);
`else
        // Loader absent: load activity must never reach the memory.
        bus.load_addr = 8'h01;
        bus.load_data = 8'hFF;
        do_fetch(8'h02, 32'h2108_0003, "noload", 1'b1);
        bus.load_req = 1'b1;
        @(negedge clk);
        check("noload_ack", 32'(bus.load_ack), 32'd0);
        check("noload_busy", 32'(bus.busy), 32'd0);
        do_fetch(8'h00, 32'h2108_0003, "noload_held", 1'b1);
        check("noload_mem", 32'(mem[1]), 32'h00);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
